// File: rtl/serial_parity_tx.sv
// Parallel-load serial transmitter: start bit, DATA_W payload bits, optional parity bit, stop bit.
// Each bit lasts div+1 clocks, using a counter in the clk domain and a valid/ready load port.
module serial_parity_tx #(
    parameter int DATA_W    = 8,
    parameter int DIV_W     = 8,
    parameter int PARITY_EN = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              parity_odd,
    input  logic [DIV_W-1:0]  div,
    output logic              tx,
    output logic              busy,
    output logic              frame_done,
    output logic              parity_bit,
    output logic [2:0]        dbg_state
);

    // Load handshake: a word transfers on the rising edge where in_valid && in_ready.
    // in_ready is high only in IDLE, including the frame_done cycle.
    // in_valid is ignored at all other times, and the producer holds in_data until the transfer.

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

    state_t              state, state_n;
    logic [DATA_W-1:0]   shift_q, shift_n;
    logic [DIV_W-1:0]    div_q, div_q_n;
    logic [DIV_W-1:0]    div_cnt, div_cnt_n;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
    logic                parity_q, parity_n;
    logic                tx_q, tx_n;
    logic                busy_q, busy_n;
    logic                done_q, done_n;
    logic                tick;
    logic                out_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift_q  <= '0;
            div_q    <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            shift_q  <= shift_n;
            div_q    <= div_q_n;
            div_cnt  <= div_cnt_n;
            bit_cnt  <= bit_cnt_n;
            parity_q <= parity_n;
            tx_q     <= tx_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    // The counter reaches zero in the last cycle of every bit period.
    assign tick = (div_cnt == '0);

    always_comb begin
        state_n   = state;
        shift_n   = shift_q;
        div_q_n   = div_q;
        div_cnt_n = div_cnt;
        bit_cnt_n = bit_cnt;
        parity_n  = parity_q;
        done_n    = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_n   = START;
                    shift_n   = in_data;
                    div_q_n   = div;
                    div_cnt_n = div;
                    bit_cnt_n = '0;
                    parity_n  = (^in_data) ^ parity_odd;
                end
            end
            START: begin
                if (tick) begin
                    state_n   = DATA;
                    div_cnt_n = div_q;
                    bit_cnt_n = '0;
                end else begin
                    div_cnt_n = div_cnt - DIV_W'(1);
                end
            end
            DATA: begin
                if (tick) begin
                    div_cnt_n = div_q;
                    shift_n   = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
                    if (bit_cnt == LAST_BIT) begin
                        state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end
                end else begin
                    div_cnt_n = div_cnt - DIV_W'(1);
                end
            end
            PARITY: begin
                if (tick) begin
                    state_n   = STOP;
                    div_cnt_n = div_q;
                end else begin
                    div_cnt_n = div_cnt - DIV_W'(1);
                end
            end
            STOP: begin
                if (tick) begin
                    state_n   = IDLE;
                    div_cnt_n = '0;
                    done_n    = 1'b1;
                end else begin
                    div_cnt_n = div_cnt - DIV_W'(1);
                end
            end
            default: begin
                state_n   = IDLE;
                div_cnt_n = '0;
            end
        endcase
    end

    // tx is registered from the next state, so the line already shows the new bit in the first cycle of that bit.
    assign out_bit = (MSB_FIRST != 0) ? shift_n[DATA_W-1] : shift_n[0];

    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = out_bit;
            PARITY:  tx_n = parity_n;
            default: tx_n = 1'b1;
        endcase
        busy_n = (state_n != IDLE);
    end

    assign in_ready   = (state == IDLE);
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign parity_bit = parity_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_serial_parity_tx.sv
// Bench for serial_parity_tx: directed and random frames compared against a per-cycle line model.
// Covers the LSB-first/parity instance and an MSB-first/no-parity instance.
module tb_serial_parity_tx;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       a_in_valid, a_parity_odd;
    logic [7:0] a_in_data, a_div;
    logic       a_in_ready, a_tx, a_busy, a_frame_done, a_parity_bit;
    logic [2:0] a_dbg;

    logic       b_in_valid, b_parity_odd;
    logic [7:0] b_in_data, b_div;
    logic       b_in_ready, b_tx, b_busy, b_frame_done, b_parity_bit;
    logic [2:0] b_dbg;

    serial_parity_tx #(.DATA_W(8), .DIV_W(8), .PARITY_EN(1), .MSB_FIRST(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .parity_odd(a_parity_odd), .div(a_div), .tx(a_tx),
        .busy(a_busy), .frame_done(a_frame_done), .parity_bit(a_parity_bit), .dbg_state(a_dbg)
    );

    serial_parity_tx #(.DATA_W(8), .DIV_W(8), .PARITY_EN(0), .MSB_FIRST(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .parity_odd(b_parity_odd), .div(b_div), .tx(b_tx),
        .busy(b_busy), .frame_done(b_frame_done), .parity_bit(b_parity_bit), .dbg_state(b_dbg)
    );

    int total = 0;
    int bad   = 0;
    logic [0:0] exp_q[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Bit positions: 0 tx, 1 parity_bit, 2 frame_done, 3 busy, 4 in_ready.
    function automatic logic [4:0] obs(input bit use_b);
        if (use_b) return {b_in_ready, b_busy, b_frame_done, b_parity_bit, b_tx};
        return {a_in_ready, a_busy, a_frame_done, a_parity_bit, a_tx};
    endfunction

    // Expected line level for every cycle of one frame.
    task automatic build_exp(input logic [7:0] d, input logic po, input int dv,
                             input bit msb, input bit pen);
        logic [0:0] bits[$];
        bits.delete();
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(msb ? d[7-i] : d[i]);
        if (pen) bits.push_back((^d) ^ po);
        bits.push_back(1'b1);
        exp_q.delete();
        foreach (bits[k]) for (int r = 0; r <= dv; r++) exp_q.push_back(bits[k]);
    endtask

    // Called at a negedge while idle; returns at the negedge of the first frame cycle.
    task automatic start_frame(input bit use_b, input logic [7:0] d, input logic po,
                               input logic [7:0] dv, input bit hold);
        chk("ready_before_accept", 16'(obs(use_b)[4]), 16'h1);
        if (use_b) begin
            b_in_valid = 1'b1; b_in_data = d; b_parity_odd = po; b_div = dv;
        end else begin
            a_in_valid = 1'b1; a_in_data = d; a_parity_odd = po; a_div = dv;
        end
        @(negedge clk);
        if (!hold) begin
            if (use_b) b_in_valid = 1'b0; else a_in_valid = 1'b0;
        end
    endtask

    // Checks the frame cycle by cycle. With limit < 0 it checks the whole frame and
    // then the frame_done cycle, and it returns at the negedge of that frame_done cycle.
    task automatic check_frame(input bit use_b, input logic [7:0] d, input logic po,
                               input int dv, input int limit);
        logic [4:0] o;
        bit msb, pen;
        msb = use_b;
        pen = !use_b;
        build_exp(d, po, dv, msb, pen);
        for (int i = 0; i < exp_q.size() && (limit < 0 || i < limit); i++) begin
            o = obs(use_b);
            chk($sformatf("tx_d%02h_c%0d", d, i + 1), 16'(o[0]), 16'(exp_q[i]));
            chk("busy_in_frame", 16'(o[3]), 16'h1);
            chk("done_in_frame", 16'(o[2]), 16'h0);
            chk("ready_in_frame", 16'(o[4]), 16'h0);
            if (limit < 0 || i + 1 < limit) @(negedge clk);
        end
        if (limit < 0) begin
            o = obs(use_b);
            chk("done_pulse", 16'(o[2]), 16'h1);
            chk("tx_idle_after_stop", 16'(o[0]), 16'h1);
            chk("busy_after_stop", 16'(o[3]), 16'h0);
            chk("ready_in_done_cycle", 16'(o[4]), 16'h1);
            if (pen) chk($sformatf("parity_d%02h_o%0d", d, po), 16'(o[1]), 16'((^d) ^ po));
        end
    endtask

    task automatic idle_cycles(input bit use_b, input int n);
        logic [4:0] o;
        repeat (n) begin
            @(negedge clk);
            o = obs(use_b);
            chk("idle_tx", 16'(o[0]), 16'h1);
            chk("idle_done", 16'(o[2]), 16'h0);
            chk("idle_busy", 16'(o[3]), 16'h0);
        end
    endtask

    task automatic full_frame(input bit use_b, input logic [7:0] d, input logic po, input logic [7:0] dv);
        start_frame(use_b, d, po, dv, 1'b0);
        check_frame(use_b, d, po, int'(dv), -1);
        idle_cycles(use_b, 1);
    endtask

    initial begin
        logic [4:0] o;
        logic [7:0] rd, rdv;
        logic       rpo;

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_parity_odd = 1'b0; a_div = '0;
        b_in_valid = 1'b0; b_in_data = '0; b_parity_odd = 1'b0; b_div = '0;
        repeat (2) @(negedge clk);
        o = obs(1'b0);
        chk("rst_tx", 16'(o[0]), 16'h1);
        chk("rst_busy", 16'(o[3]), 16'h0);
        chk("rst_ready", 16'(o[4]), 16'h1);
        chk("rst_done", 16'(o[2]), 16'h0);
        chk("rst_parity", 16'(o[1]), 16'h0);
        chk("rst_b_tx", 16'(obs(1'b1)[0]), 16'h1);
        rst_n = 1'b1;
        idle_cycles(1'b0, 2);

        // Reference frame and the parity modes.
        full_frame(1'b0, 8'hA5, 1'b0, 8'd0);
        full_frame(1'b0, 8'h01, 1'b0, 8'd0);
        full_frame(1'b0, 8'h01, 1'b1, 8'd0);
        full_frame(1'b0, 8'h00, 1'b1, 8'd0);

        // Divider, including the all-ones value.
        full_frame(1'b0, 8'hA5, 1'b0, 8'd3);
        full_frame(1'b0, 8'hA5, 1'b0, 8'd255);

        // MSB-first instance without a parity bit.
        full_frame(1'b1, 8'h0F, 1'b0, 8'd0);
        full_frame(1'b1, 8'(($urandom_range(0, 255))), 1'b0, 8'(($urandom_range(0, 3))));

        // The held word must wait for the running frame and then start back-to-back.
        start_frame(1'b0, 8'hA5, 1'b0, 8'd0, 1'b1);
        a_in_data = 8'h3C; a_parity_odd = 1'b0; a_div = 8'd0;
        check_frame(1'b0, 8'hA5, 1'b0, 0, -1);
        @(negedge clk);
        a_in_valid = 1'b0;
        check_frame(1'b0, 8'h3C, 1'b0, 0, -1);
        idle_cycles(1'b0, 1);

        // Random frames; these inputs change while the frame is busy and must not affect it.
        for (int n = 0; n < 8; n++) begin
            rd  = 8'($urandom_range(0, 255));
            rpo = 1'($urandom_range(0, 1));
            rdv = 8'($urandom_range(0, 4));
            start_frame(1'b0, rd, rpo, rdv, 1'b0);
            a_in_data = ~rd; a_parity_odd = ~rpo; a_div = rdv + 8'd2;
            check_frame(1'b0, rd, rpo, int'(rdv), -1);
            if (n[0]) idle_cycles(1'b0, 1);
        end
        idle_cycles(1'b0, 1);

        // Reset during DATA aborts the frame at once, without a frame_done pulse.
        start_frame(1'b0, 8'hA5, 1'b0, 8'd3, 1'b0);
        check_frame(1'b0, 8'hA5, 1'b0, 3, 10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        o = obs(1'b0);
        chk("abort_tx", 16'(o[0]), 16'h1);
        chk("abort_busy", 16'(o[3]), 16'h0);
        chk("abort_ready", 16'(o[4]), 16'h1);
        chk("abort_done", 16'(o[2]), 16'h0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 16'(obs(1'b0)[2]), 16'h0);
        end
        rst_n = 1'b1;
        idle_cycles(1'b0, 2);
        full_frame(1'b0, 8'hA5, 1'b0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
